// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, parameter defaults and sizing helper for the I/D memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, I_BURST, I_DRAIN, D_ACCESS} state_t;
    localparam int LINE_WORDS_DEF = 4;
    localparam int STARVE_MAX_DEF = 8;
    function automatic int beat_bits(input int words);
        return $clog2(words);
    endfunction
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: D-first arbitration with a saturating I-side loss counter that forces an I grant
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic arb,
    input  logic i_req,
    input  logic d_req,
    output logic gnt_i,
    output logic gnt_d
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] cnt;
    logic starved;
    always_comb begin
        starved = cnt == CW'(STARVE_MAX);
        gnt_i = arb && i_req && (!d_req || starved);
        gnt_d = arb && d_req && !gnt_i;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (gnt_i) cnt <= '0;
        else if (gnt_d && i_req && !starved) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between I-cache line refills and single-word D accesses
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cancel,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_last,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);
    localparam int BW = beat_bits(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    state_t state, state_nx;
    logic [BW-1:0] beat;
    logic [31:0] addr_q, wdata_q;
    logic we_q, last;

    // Arbitration is gated by reset so grants are silent the moment rst falls
    mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk   (clk),
        .rst   (rst),
        .arb   (rst && state == IDLE),
        .i_req (i_req && !i_cancel),
        .d_req (d_req),
        .gnt_i (i_gnt),
        .gnt_d (d_gnt)
    );

    always_comb begin
        last = beat == BW'(LINE_WORDS - 1);
        m_req = state != IDLE;
        m_we = m_req && we_q;
        m_addr = addr_q;
        m_wdata = wdata_q;
        i_rvalid = state == I_BURST && m_ack;
        i_last = i_rvalid && last;
        i_rdata = state == I_BURST ? m_rdata : '0;
        d_done = state == D_ACCESS && m_ack;
        d_rdata = state == D_ACCESS ? m_rdata : '0;
        state_nx = state;
        case (state)
            IDLE:     state_nx = i_gnt ? I_BURST : d_gnt ? D_ACCESS : IDLE;
            I_BURST:  state_nx = (m_ack && (last || i_cancel)) ? IDLE : i_cancel ? I_DRAIN : I_BURST;
            I_DRAIN:  state_nx = m_ack ? IDLE : I_DRAIN;
            D_ACCESS: state_nx = m_ack ? IDLE : D_ACCESS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (i_gnt) begin
                addr_q <= i_addr & ~LINE_MASK;
                wdata_q <= '0;
                we_q <= 1'b0;
                beat <= '0;
            end else if (d_gnt) begin
                addr_q <= d_addr;
                wdata_q <= d_wdata;
                we_q <= d_we;
            end else if (i_rvalid && !last) begin
                addr_q <= addr_q + 32'd4;
                beat <= beat + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a transaction-level reference model checked every cycle
module tb_mem_arbiter;
    localparam int LW = 4;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    logic rst, i_req, i_cancel, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic i_gnt, i_rvalid, i_last, d_gnt, d_done, m_req, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    mem_arbiter #(.LINE_WORDS(LW), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_last(i_last),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int ack_delay = 0, w = 0;
    // model: kind 0 = nothing outstanding, 1 = line refill, 2 = abandoned refill beat, 3 = data access
    int kind = 0, k = 0, losses = 0;
    logic [31:0] base = '0, daddr = '0, dwdata = '0;
    logic dwe = 1'b0;
    logic e_ig, e_dg;
    int n_ig, n_dg, n_rv, n_il, il_at, n_dd, cnt_at_ig, cnt_after_ig;
    int gorder[$];
    logic [31:0] beats[$];
    logic [31:0] done_addr, done_wdata;
    logic done_we, after_ig = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always_comb begin
        e_ig = rst && kind == 0 && i_req && !i_cancel && (!d_req || losses == STARVE);
        e_dg = rst && kind == 0 && d_req && !e_ig;
    end

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            kind = 0;
            k = 0;
            losses = 0;
        end else if (kind == 0) begin
            if (e_ig) begin
                kind = 1;
                k = 0;
                base = i_addr & ~32'(LW * 4 - 1);
                losses = 0;
            end else if (e_dg) begin
                kind = 3;
                daddr = d_addr;
                dwe = d_we;
                dwdata = d_wdata;
                if (i_req && !i_cancel && losses < STARVE) losses++;
            end
        end else if (kind == 1) begin
            if (m_ack) begin
                if (k == LW - 1 || i_cancel) kind = 0;
                else k++;
            end else if (i_cancel) kind = 2;
        end else if (m_ack) kind = 0;
    end

    // memory responder: each beat is acked after ack_delay wait cycles
    initial forever begin
        @(posedge clk);
        w = (m_req && !m_ack) ? w + 1 : 0;
        #1;
        m_ack = m_req && w >= ack_delay;
        m_rdata = $urandom;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_ctl", {25'b0, i_gnt, i_rvalid, i_last, d_gnt, d_done, m_req, m_we}, 0);
            chk("rst_data", i_rdata | d_rdata | m_addr | m_wdata, 0);
            chk("rst_starve", 32'(dut.u_prio.cnt), 0);
            chk("rst_beat", 32'(dut.beat), 0);
        end else begin
            chk("i_gnt", i_gnt, e_ig);
            chk("d_gnt", d_gnt, e_dg);
            chk("m_req", m_req, kind != 0);
            if (kind == 1 || kind == 2) chk("m_addr_i", m_addr, base + 32'(4 * k));
            if (kind == 3) chk("m_addr_d", m_addr, daddr);
            if (kind != 0) chk("m_we", m_we, kind == 3 && dwe);
            if (kind == 3 && dwe) chk("m_wdata", m_wdata, dwdata);
            chk("i_rvalid", i_rvalid, kind == 1 && m_ack);
            chk("i_last", i_last, kind == 1 && m_ack && k == LW - 1);
            if (kind == 1 && m_ack) chk("i_rdata", i_rdata, m_rdata);
            chk("d_done", d_done, kind == 3 && m_ack);
            if (kind == 3 && m_ack && !dwe) chk("d_rdata", d_rdata, m_rdata);
            chk("starve", 32'(dut.u_prio.cnt), losses);
            if (after_ig) begin
                cnt_after_ig = 32'(dut.u_prio.cnt);
                after_ig = 1'b0;
            end
            if (i_gnt) begin
                n_ig++;
                gorder.push_back(1);
                cnt_at_ig = 32'(dut.u_prio.cnt);
                after_ig = 1'b1;
            end
            if (d_gnt) begin
                n_dg++;
                gorder.push_back(0);
            end
            if (i_rvalid) begin
                n_rv++;
                if (i_last) begin
                    n_il++;
                    il_at = n_rv;
                end
            end
            if (m_req && m_ack) beats.push_back(m_addr);
            if (d_done) begin
                n_dd++;
                done_addr = m_addr;
                done_wdata = m_wdata;
                done_we = m_we;
            end
        end
    end

    task automatic clear();
        n_ig = 0; n_dg = 0; n_rv = 0; n_il = 0; il_at = 0; n_dd = 0;
        gorder.delete();
        beats.delete();
    endtask

    task automatic wait_ig(input int lim);
        for (int c = 0; c < lim && n_ig < 1; c++) cyc(1);
        if (n_ig < 1) chk("timeout_igrant", n_ig, 1);
    endtask

    task automatic wait_dg(input int lim);
        for (int c = 0; c < lim && n_dg < 1; c++) cyc(1);
        if (n_dg < 1) chk("timeout_dgrant", n_dg, 1);
    endtask

    task automatic wait_rv(input int target, input int lim);
        for (int c = 0; c < lim && n_rv < target; c++) cyc(1);
        if (n_rv < target) chk("timeout_rvalid", n_rv, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int pos;
        rst = 1'b0; i_req = 1'b0; i_cancel = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        clear();
        cyc(3);
        rst = 1'b1;

        // I-only refill, ack every second cycle
        ack_delay = 1;
        clear();
        i_req = 1'b1; i_addr = 32'h1000_0014;
        wait_ig(5);
        i_req = 1'b0;
        wait_rv(4, 40);
        cyc(2);
        chk("s1_nrv", n_rv, 4);
        chk("s1_nlast", n_il, 1);
        chk("s1_last_at", il_at, 4);
        chk("s1_nbeats", beats.size(), 4);
        chk("s1_b0", beats[0], 32'h1000_0010);
        chk("s1_b1", beats[1], 32'h1000_0014);
        chk("s1_b2", beats[2], 32'h1000_0018);
        chk("s1_b3", beats[3], 32'h1000_001C);

        // contention: D wins 8 times, then I is forced
        ack_delay = 0;
        clear();
        d_we = 1'b0; d_addr = 32'h0000_0100; i_addr = 32'h3000_0000;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 200 && !(n_dg >= 10 && n_ig >= 1); c++) begin
            cyc(1);
            if (n_ig > 0) i_req = 1'b0;
            if (n_dg >= 10) d_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc(3);
        pos = -1;
        foreach (gorder[j]) if (gorder[j] == 1 && pos < 0) pos = j;
        chk("s2_ndg", n_dg, 10);
        chk("s2_nig", n_ig, 1);
        chk("s2_ipos", pos, 8);
        chk("s2_cnt_at_i", cnt_at_ig, 8);
        chk("s2_cnt_after_i", cnt_after_ig, 0);

        // cancel during beat 1 with a slow ack
        ack_delay = 3;
        clear();
        i_req = 1'b1; i_addr = 32'h4000_0000;
        wait_ig(5);
        i_req = 1'b0;
        wait_rv(1, 20);
        i_cancel = 1'b1;
        cyc(1);
        i_cancel = 1'b0;
        cyc(10);
        chk("s3_nrv", n_rv, 1);
        chk("s3_nbeats", beats.size(), 2);
        chk("s3_b1", beats[1], 32'h4000_0004);
        chk("s3_mreq", m_req, 0);

        // D store
        ack_delay = 2;
        clear();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0008; d_wdata = 32'hDEAD_BEEF;
        wait_dg(5);
        d_req = 1'b0;
        for (int c = 0; c < 20 && n_dd < 1; c++) cyc(1);
        cyc(2);
        chk("s4_ndone", n_dd, 1);
        chk("s4_addr", done_addr, 32'h2000_0008);
        chk("s4_wdata", done_wdata, 32'hDEAD_BEEF);
        chk("s4_we", done_we, 1);
        chk("s4_nrv", n_rv, 0);
        d_we = 1'b0;

        // reset in the beat-2 wait, then a fresh refill
        ack_delay = 2;
        clear();
        i_req = 1'b1; i_addr = 32'h5000_0040;
        wait_ig(5);
        i_req = 1'b0;
        wait_rv(2, 30);
        #2;
        rst = 1'b0;
        #1;
        chk("s5_mreq", m_req, 0);
        chk("s5_rvalid", i_rvalid, 0);
        chk("s5_gnt", i_gnt | d_gnt, 0);
        chk("s5_maddr", m_addr, 0);
        cyc(2);
        rst = 1'b1;
        clear();
        ack_delay = 0;
        i_req = 1'b1;
        cyc(1);
        chk("s5_first_arb", n_ig, 1);
        i_req = 1'b0;
        wait_rv(4, 20);
        chk("s5_b0", beats[0], 32'h5000_0040);
        chk("s5_nrv", n_rv, 4);

        // cancel with request in IDLE suppresses the grant for one cycle
        clear();
        d_req = 1'b0; i_cancel = 1'b1; i_req = 1'b1; i_addr = 32'h6000_0000;
        @(negedge clk); #1;
        chk("s6_nogrant", i_gnt, 0);
        cyc(1);
        i_cancel = 1'b0;
        @(negedge clk); #1;
        chk("s6_grant", i_gnt, 1);
        cyc(1);
        i_req = 1'b0;
        wait_rv(4, 20);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, giving the words per I-side refill burst (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_MAX, default 8, giving the consecutive I-side losses before I-side gets forced priority.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 i_req  in  1  I-cache refill request; held until i_gnt.
REQ-006 i_addr  in  32  refill address; low log2(LINE_WORDS)+2 bits ignored.
REQ-007 i_cancel  in  1  pipeline flush; abandons the pending or in-flight refill.
REQ-008 i_gnt  out  1  one-cycle grant pulse to I-side.
REQ-009 i_rvalid / i_rdata / i_last  out  1/32/1  refill beat valid, data, final beat.
REQ-010 d_req, d_we  in  1,1  data-memory request and write enable; held until d_gnt.
REQ-011 d_addr, d_wdata  in  32,32  word address and store data.
REQ-012 d_gnt, d_done  out  1,1  grant pulse; completion pulse.
REQ-013 d_rdata  out  32  load data, valid with d_done when d_we=0.
REQ-014 m_req, m_we  out  1,1  backing-memory beat request and write.
REQ-015 m_addr, m_wdata  out  32,32  backing-memory address and data.
REQ-016 m_ack, m_rdata  in  1,32  beat accept/complete; read data valid with m_ack.

Function
REQ-017 SHALL implement states IDLE, I_BURST, I_DRAIN, D_ACCESS.
REQ-018 In IDLE, when both requests are present, SHALL grant D, unless the starvation counter equals STARVE_MAX, in which case SHALL grant I.
REQ-019 The starvation counter SHALL increment, saturating at STARVE_MAX, on each IDLE cycle where I requests and D is granted, and SHALL clear on any I grant.
REQ-020 A grant SHALL pulse i_gnt or d_gnt for exactly one cycle, in the IDLE cycle of decision, and SHALL latch the address, we and wdata.
REQ-021 i_cancel high in IDLE SHALL suppress any I grant that cycle; D arbitration SHALL proceed normally.
REQ-022 I_BURST SHALL issue LINE_WORDS beats at line base + 4*k, k = 0..LINE_WORDS-1, with m_we=0.
REQ-023 m_req SHALL stay high, with stable m_addr, m_we and m_wdata, until m_ack; beat k+1 SHALL start the cycle after ack k.
REQ-024 In I_BURST: i_rvalid = m_ack, i_rdata = m_rdata (same cycle), and i_last = m_ack on beat LINE_WORDS-1.
REQ-025 After the last ack, the block SHALL return to IDLE.
REQ-026 i_cancel in I_BURST SHALL move the block to I_DRAIN, or directly to IDLE if m_ack is high that cycle.
REQ-027 I_DRAIN SHALL hold the outstanding beat until m_ack, with i_rvalid forced 0, then go to IDLE.
REQ-028 D_ACCESS SHALL issue one beat; d_done = m_ack, d_rdata = m_rdata; then IDLE.
REQ-029 i_cancel SHALL have no effect on D_ACCESS.
REQ-030 The beat counter SHALL be log2(LINE_WORDS) bits, reset per burst, and no wrap beyond LINE_WORDS-1 SHALL be reachable.
REQ-031 There SHALL be no grant in the cycle a transaction completes; the first IDLE cycle after completion arbitrates, giving a one-cycle turnaround.
REQ-032 Outside an active beat, m_req SHALL be 0 and every response pulse output SHALL be 0.

Reset
REQ-033 While rst=0, the block SHALL enter IDLE immediately, including mid-burst, abandoning the beat.
REQ-034 While rst=0, all outputs, data and address outputs included, SHALL be 0, and the starvation and beat counters SHALL be 0.
REQ-035 After rst deasserts, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum, the LINE_WORDS and STARVE_MAX defaults, and the beat-counter width function.
REQ-037 The starvation counter with priority select SHALL be sub-module mem_arb_priority; all other logic stays in mem_arbiter.

Verification
REQ-038 I-only: i_addr=0x1000_0014, m_ack every 2nd cycle -> beats at 0x1000_0010/14/18/1C, four i_rvalid, i_last on the 4th.
REQ-039 Contention: i_req and d_req held, D issues 10 back-to-back loads -> D granted 8 times, the 9th grant goes to I, and the counter reads 0 after it.
REQ-040 Cancel mid-burst at beat 1 with m_ack delayed 3 cycles -> m_req held until the ack, no further i_rvalid, IDLE next, no beat 2 issued.
REQ-041 D store d_addr=0x2000_0008, d_wdata=0xDEAD_BEEF -> m_we=1 with matching m_addr/m_wdata, d_done with m_ack, and no i_rvalid.
REQ-042 Reset asserted in the I_BURST beat-2 wait -> same-cycle m_req=0 and all outputs 0; after release, a fresh i_req restarts at beat 0.
REQ-043 Simultaneous i_cancel and i_req in IDLE with d_req=0 -> no grant; the next cycle, with cancel low, grants I.
